ftoi_pipe: RTL and testbench
============================

// Module: ftoi_pipe
// PURPOSE
//   Pipelined float32 -> integer converter for the FPU, parametrised in integer
//   width. Adds selectable rounding, signed/unsigned mode, IEEE-style status
//   flags and a real valid/ready handshake with backpressure.
//   Sits beside the other FPU units; 2-cycle latency, one conversion per cycle.
// PARAMETERS
//   INT_W  32  result width in bits; legal range 8..64
// PORTS
//   clk          in   1      clock, all state on rising edge
//   rstn         in   1      reset, asynchronous, active-low
//   s_valid      in   1      input operand valid
//   s_ready      out  1      converter can accept an operand this cycle
//   x            in   32     float32 operand
//   rmode        in   2      00 RNE, 01 RTZ, 10 RDN (floor), 11 RUP (ceil)
//   is_unsigned  in   1      1: unsigned result range, 0: two's complement
//   m_valid      out  1      result valid
//   m_ready      in   1      downstream accepts result
//   y            out  INT_W  converted integer
//   flags        out  3      {invalid, overflow, inexact}
// BEHAVIOUR
// - Reset (rstn low, async): both stage valid bits, m_valid, y, flags -> 0;
//   s_ready held 0 while rstn low. In-flight operands are discarded.
// - Handshake: transfer on s_valid&s_ready / m_valid&m_ready. Global enable
//   en = !m_valid | m_ready; s_ready = en. On en both stages advance, stage-1
//   valid <= s_valid. While en=0 all pipeline regs, y, flags, m_valid hold.
//   x, rmode, is_unsigned are sampled together on acceptance.
// - Latency: accepted in cycle N -> m_valid/y/flags registered at edge N+2
//   with no stall. Bubbles propagate as valid=0; order always preserved.
// - Stage 1: split s/e/m; e==0 -> magnitude zero (denormals flushed, no
//   inexact); E=e-127; E<0 -> int part 0, fraction nonzero; else shift
//   {1,m} left by E into INT_W+1 integer bits, keep guard bit and sticky OR.
//   E>=INT_W+1 -> range flag without shifting.
// - Stage 2 rounding increment: RNE guard&(sticky|lsb); RTZ 0;
//   RDN s&(guard|sticky); RUP !s&(guard|sticky). Add to magnitude
//   (INT_W+1 bits, carry kept), then negate if s.
// - Range (signed): [-2^(INT_W-1), 2^(INT_W-1)-1]; exact -2^(INT_W-1) is legal.
//   Range (unsigned): [0, 2^INT_W-1]; negative value rounding to 0 gives 0.
// - e==255: NaN -> max positive of mode range; +Inf -> max; -Inf -> signed
//   min / unsigned 0; flags=100.
// - Finite out of range after rounding: saturate toward sign (max or signed
//   min / unsigned 0); flags=010.
// - Otherwise flags=001 if guard|sticky, else 000. Flags mutually exclusive.
//   Zero of either sign -> y=0, flags=000.
// - No combinational path from x to y; s_ready depends on m_valid, m_ready.
// TESTING (INT_W=32 unless stated)
// - 0x40200000 (2.5) in rmodes 00/01/10/11 -> y=2/2/2/3, flags=001 each.
// - 0xC0200000 (-2.5): RNE -> 0xFFFFFFFE, RDN -> 0xFFFFFFFD, RUP -> 0xFFFFFFFE;
//   flags=001.
// - Signed 0xCF000000 (-2^31) -> 0x80000000 flags 000; 0x4F000000 (2^31)
//   -> 0x7FFFFFFF flags 010; 0x7FC00000 (NaN) -> 0x7FFFFFFF flags 100.
// - Unsigned: 0x4F800000 (2^32) -> 0xFFFFFFFF flags 010; 0xBF000000 (-0.5)
//   RTZ -> 0 flags 001; 0xBFC00000 (-1.5) RTZ -> 0 flags 010.
// - 4 back-to-back operands, m_ready low 3 cycles after first m_valid:
//   s_ready=0 during stall, y/flags stable, all 4 results delivered in order.
// - rstn pulsed low with 2 ops in flight: m_valid drops immediately, no stale
//   result after release; INT_W=8 rerun: 0x43000000 (128) signed -> 0x7F, 010.

Source files
------------

// File: rtl/ftoi_pipe.sv
// ftoi_pipe: two-stage pipelined float32 -> integer converter.
//
// Stage 1 unpacks the operand and aligns the significand into an integer
// magnitude plus guard/sticky bits. Stage 2 rounds, range-checks and
// saturates. A single global enable advances both stages, so backpressure
// on the result side stalls the whole pipe. Order is always preserved.
//
// Ports:
//   clk          clock, all state on rising edge
//   rstn         asynchronous active-low reset
//   s_valid      operand valid
//   s_ready      operand accepted this cycle when high
//   x            float32 operand
//   rmode        00 RNE, 01 RTZ, 10 RDN (floor), 11 RUP (ceil)
//   is_unsigned  1: unsigned result range, 0: two's complement
//   m_valid      result valid
//   m_ready      downstream accepts result
//   y            converted integer (INT_W bits)
//   flags        {invalid, overflow, inexact}
module ftoi_pipe #(
  parameter int unsigned INT_W = 32  // legal range 8..64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      x,
  input  logic [1:0]       rmode,
  input  logic             is_unsigned,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [INT_W-1:0] y,
  output logic [2:0]       flags
);

  // Significand (24 bits) shifted left by up to INT_W positions.
  localparam int unsigned ExtW = INT_W + 24;

  // Magnitude limits, compared against the (INT_W+2)-bit rounded sum.
  localparam logic [INT_W+1:0] LimSPos = {3'b000, {(INT_W - 1){1'b1}}};
  localparam logic [INT_W+1:0] LimSNeg = {3'b001, {(INT_W - 1){1'b0}}};
  localparam logic [INT_W+1:0] LimU    = {2'b00, {INT_W{1'b1}}};

  logic en;

  // ---------------------------------------------------------------------
  // Stage 1: unpack and align
  // ---------------------------------------------------------------------
  logic            sign_d;
  logic [7:0]      exp_b;
  logic [22:0]     man;
  int              exp_unb;
  logic [ExtW-1:0] ext;
  logic [ExtW-1:0] shifted;
  logic [INT_W:0]  mag_d;
  logic            guard_d, sticky_d, nan_d, inf_d, big_d;

  always_comb begin
    sign_d   = x[31];
    exp_b    = x[30:23];
    man      = x[22:0];
    exp_unb  = int'(exp_b) - 127;
    ext      = {{INT_W{1'b0}}, 1'b1, man};
    shifted  = '0;
    mag_d    = '0;
    guard_d  = 1'b0;
    sticky_d = 1'b0;
    nan_d    = 1'b0;
    inf_d    = 1'b0;
    big_d    = 1'b0;
    if (exp_b == 8'hFF) begin
      nan_d = (man != '0);
      inf_d = (man == '0);
    end else if (exp_b == 8'h00) begin
      // Zero and denormals: flushed to an exact zero magnitude.
    end else if (exp_unb < 0) begin
      // Pure fraction: only 2^-1 lands in the guard position.
      guard_d  = (exp_unb == -1);
      sticky_d = (exp_unb == -1) ? |man : 1'b1;
    end else if (exp_unb > int'(INT_W)) begin
      // Too large for even the INT_W+1 bit magnitude; skip the shifter.
      big_d = 1'b1;
    end else begin
      // Binary point sits between bits 23 and 22 of the shifted value.
      shifted  = ext << exp_unb[6:0];
      mag_d    = shifted[ExtW-1:23];
      guard_d  = shifted[22];
      sticky_d = |shifted[21:0];
    end
  end

  logic           v1_q;
  logic           sign1_q;
  logic [INT_W:0] mag1_q;
  logic           guard1_q, sticky1_q, nan1_q, inf1_q, big1_q;
  logic [1:0]     rmode1_q;
  logic           uns1_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q      <= 1'b0;
      sign1_q   <= 1'b0;
      mag1_q    <= '0;
      guard1_q  <= 1'b0;
      sticky1_q <= 1'b0;
      nan1_q    <= 1'b0;
      inf1_q    <= 1'b0;
      big1_q    <= 1'b0;
      rmode1_q  <= 2'b00;
      uns1_q    <= 1'b0;
    end else if (en) begin
      v1_q <= s_valid;
      if (s_valid) begin
        sign1_q   <= sign_d;
        mag1_q    <= mag_d;
        guard1_q  <= guard_d;
        sticky1_q <= sticky_d;
        nan1_q    <= nan_d;
        inf1_q    <= inf_d;
        big1_q    <= big_d;
        rmode1_q  <= rmode;
        uns1_q    <= is_unsigned;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: round, range-check, saturate
  // ---------------------------------------------------------------------
  logic             inc;
  logic             inexact;
  logic [INT_W+1:0] sum;
  logic [INT_W-1:0] mag_t;
  logic [INT_W-1:0] max_val;
  logic [INT_W-1:0] neg_sat;
  logic             in_range;
  logic [INT_W-1:0] y_d;
  logic [2:0]       flags_d;

  always_comb begin
    inexact = guard1_q | sticky1_q;
    case (rmode1_q)
      2'b00:   inc = guard1_q & (sticky1_q | mag1_q[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = sign1_q & inexact;
      default: inc = ~sign1_q & inexact;
    endcase
    sum   = {1'b0, mag1_q} + {{(INT_W + 1){1'b0}}, inc};
    mag_t = sum[INT_W-1:0];

    max_val = uns1_q ? {INT_W{1'b1}} : {1'b0, {(INT_W - 1){1'b1}}};
    neg_sat = uns1_q ? {INT_W{1'b0}} : {1'b1, {(INT_W - 1){1'b0}}};

    if (uns1_q) begin
      in_range = sign1_q ? (sum == '0) : (sum <= LimU);
    end else begin
      in_range = sign1_q ? (sum <= LimSNeg) : (sum <= LimSPos);
    end

    y_d     = '0;
    flags_d = 3'b000;
    if (nan1_q) begin
      y_d     = max_val;
      flags_d = 3'b100;
    end else if (inf1_q) begin
      y_d     = sign1_q ? neg_sat : max_val;
      flags_d = 3'b100;
    end else if (big1_q || !in_range) begin
      y_d     = sign1_q ? neg_sat : max_val;
      flags_d = 3'b010;
    end else begin
      y_d     = sign1_q ? (~mag_t + {{(INT_W - 1){1'b0}}, 1'b1}) : mag_t;
      flags_d = {2'b00, inexact};
    end
  end

  logic             m_valid_q;
  logic [INT_W-1:0] y_q;
  logic [2:0]       flags_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid_q <= 1'b0;
      y_q       <= '0;
      flags_q   <= 3'b000;
    end else if (en) begin
      m_valid_q <= v1_q;
      if (v1_q) begin
        y_q     <= y_d;
        flags_q <= flags_d;
      end
    end
  end

  // The whole pipe moves whenever the output register is empty or draining.
  assign en      = ~m_valid_q | m_ready;
  assign s_ready = en & rstn;
  assign m_valid = m_valid_q;
  assign y       = y_q;
  assign flags   = flags_q;

endmodule

// File: tb/tb_ftoi_pipe.sv
// Testbench for ftoi_pipe: vector table through a scoreboard with random
// backpressure, a stall sequence, a reset-in-flight sequence and an INT_W=8
// instance with exact latency checks.
module tb_ftoi_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        s_valid, s_ready, m_valid, m_ready, is_unsigned;
  logic [31:0] x, y;
  logic [1:0]  rmode;
  logic [2:0]  flags;

  logic        s_valid8, s_ready8, m_valid8, is_unsigned8;
  logic        m_ready8;
  logic [31:0] x8;
  logic [1:0]  rmode8;
  logic [7:0]  y8;
  logic [2:0]  flags8;

  ftoi_pipe #(.INT_W(32)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .x(x),
    .rmode(rmode), .is_unsigned(is_unsigned), .m_valid(m_valid),
    .m_ready(m_ready), .y(y), .flags(flags)
  );

  ftoi_pipe #(.INT_W(8)) dut8 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid8), .s_ready(s_ready8), .x(x8),
    .rmode(rmode8), .is_unsigned(is_unsigned8), .m_valid(m_valid8),
    .m_ready(m_ready8), .y(y8), .flags(flags8)
  );

  typedef struct {
    logic [31:0] x;
    logic [1:0]  rm;
    logic        uns;
    logic [31:0] y;
    logic [2:0]  f;
  } vec_t;

  typedef struct {
    logic [31:0] y;
    logic [2:0]  f;
    int          id;
  } exp_t;

  localparam int NV = 36;
  vec_t vecs[NV];
  vec_t vecs8[5];
  exp_t exp_q[$];
  exp_t e_mon;

  int checks = 0;
  int passes = 0;
  bit rand_bp = 1'b0;

  function automatic vec_t mk(logic [31:0] xv, logic [1:0] rm, logic uns,
                              logic [31:0] yv, logic [2:0] f);
    vec_t v;
    v.x = xv; v.rm = rm; v.uns = uns; v.y = yv; v.f = f;
    return v;
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s[%0d]: got %h, expected %h", name, id, act, exp);
  endtask

  task automatic send(input vec_t v, input int id);
    int   n;
    exp_t e;
    n = 0;
    s_valid = 1'b1; x = v.x; rmode = v.rm; is_unsigned = v.uns;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept", id, 32'(s_ready), 32'd1);
    e.y = v.y; e.f = v.f; e.id = id;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain", -1, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: results are compared in the cycle they transfer.
  always @(negedge clk) begin
    if (rstn && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_m_valid", -1, 32'(m_valid), 32'd0);
      end else begin
        e_mon = exp_q.pop_front();
        chk("y", e_mon.id, y, e_mon.y);
        chk("flags", e_mon.id, 32'(flags), 32'(e_mon.f));
      end
    end
  end

  // Random backpressure while the vector table runs.
  always begin
    @(posedge clk); #2;
    if (rand_bp) m_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1);
  end

  initial begin
    int cnt;
    vecs[0]  = mk(32'h40200000, 2'd0, 1'b0, 32'h00000002, 3'b001);
    vecs[1]  = mk(32'h40200000, 2'd1, 1'b0, 32'h00000002, 3'b001);
    vecs[2]  = mk(32'h40200000, 2'd2, 1'b0, 32'h00000002, 3'b001);
    vecs[3]  = mk(32'h40200000, 2'd3, 1'b0, 32'h00000003, 3'b001);
    vecs[4]  = mk(32'hC0200000, 2'd0, 1'b0, 32'hFFFFFFFE, 3'b001);
    vecs[5]  = mk(32'hC0200000, 2'd2, 1'b0, 32'hFFFFFFFD, 3'b001);
    vecs[6]  = mk(32'hC0200000, 2'd3, 1'b0, 32'hFFFFFFFE, 3'b001);
    vecs[7]  = mk(32'hCF000000, 2'd0, 1'b0, 32'h80000000, 3'b000);
    vecs[8]  = mk(32'h4F000000, 2'd0, 1'b0, 32'h7FFFFFFF, 3'b010);
    vecs[9]  = mk(32'h7FC00000, 2'd0, 1'b0, 32'h7FFFFFFF, 3'b100);
    vecs[10] = mk(32'h4F800000, 2'd0, 1'b1, 32'hFFFFFFFF, 3'b010);
    vecs[11] = mk(32'hBF000000, 2'd1, 1'b1, 32'h00000000, 3'b001);
    vecs[12] = mk(32'hBFC00000, 2'd1, 1'b1, 32'h00000000, 3'b010);
    vecs[13] = mk(32'h3F800000, 2'd0, 1'b0, 32'h00000001, 3'b000);
    vecs[14] = mk(32'hBF800000, 2'd0, 1'b0, 32'hFFFFFFFF, 3'b000);
    vecs[15] = mk(32'h00000000, 2'd0, 1'b0, 32'h00000000, 3'b000);
    vecs[16] = mk(32'h80000000, 2'd3, 1'b1, 32'h00000000, 3'b000);
    vecs[17] = mk(32'h00400000, 2'd3, 1'b0, 32'h00000000, 3'b000);
    vecs[18] = mk(32'h3F400000, 2'd0, 1'b0, 32'h00000001, 3'b001);
    vecs[19] = mk(32'h40600000, 2'd0, 1'b0, 32'h00000004, 3'b001);
    vecs[20] = mk(32'h3F000000, 2'd0, 1'b0, 32'h00000000, 3'b001);
    vecs[21] = mk(32'hBF000000, 2'd2, 1'b0, 32'hFFFFFFFF, 3'b001);
    vecs[22] = mk(32'h3E800000, 2'd3, 1'b0, 32'h00000001, 3'b001);
    vecs[23] = mk(32'hFF800000, 2'd0, 1'b0, 32'h80000000, 3'b100);
    vecs[24] = mk(32'hFF800000, 2'd0, 1'b1, 32'h00000000, 3'b100);
    vecs[25] = mk(32'h7F800000, 2'd0, 1'b1, 32'hFFFFFFFF, 3'b100);
    vecs[26] = mk(32'h7FC00000, 2'd0, 1'b1, 32'hFFFFFFFF, 3'b100);
    vecs[27] = mk(32'h4EFFFFFF, 2'd0, 1'b0, 32'h7FFFFF80, 3'b000);
    vecs[28] = mk(32'h4F7FFFFF, 2'd1, 1'b1, 32'hFFFFFF00, 3'b000);
    vecs[29] = mk(32'hCF000001, 2'd0, 1'b0, 32'h80000000, 3'b010);
    vecs[30] = mk(32'hC0200000, 2'd1, 1'b0, 32'hFFFFFFFE, 3'b001);
    vecs[31] = mk(32'hBFC00000, 2'd0, 1'b0, 32'hFFFFFFFE, 3'b001);
    vecs[32] = mk(32'h3E800000, 2'd2, 1'b1, 32'h00000000, 3'b001);
    vecs[33] = mk(32'h4F800000, 2'd0, 1'b0, 32'h7FFFFFFF, 3'b010);
    vecs[34] = mk(32'h50000000, 2'd0, 1'b1, 32'hFFFFFFFF, 3'b010);
    vecs[35] = mk(32'hD0000000, 2'd0, 1'b0, 32'h80000000, 3'b010);

    vecs8[0] = mk(32'h43000000, 2'd0, 1'b0, 32'h7F, 3'b010);
    vecs8[1] = mk(32'hC3000000, 2'd0, 1'b0, 32'h80, 3'b000);
    vecs8[2] = mk(32'h437F0000, 2'd1, 1'b1, 32'hFF, 3'b000);
    vecs8[3] = mk(32'h43800000, 2'd0, 1'b1, 32'hFF, 3'b010);
    vecs8[4] = mk(32'h3FC00000, 2'd0, 1'b0, 32'h02, 3'b001);

    rstn = 1'b1; s_valid = 1'b0; x = '0; rmode = 2'd0; is_unsigned = 1'b0; m_ready = 1'b1;
    s_valid8 = 1'b0; x8 = '0; rmode8 = 2'd0; is_unsigned8 = 1'b0; m_ready8 = 1'b1;
    #3 rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_m_valid", 0, 32'(m_valid), 32'd0);
    chk("reset_s_ready", 0, 32'(s_ready), 32'd0);
    chk("reset_y", 0, y, 32'd0);
    chk("reset_flags", 0, 32'(flags), 32'd0);
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk("s_ready_after_reset", 0, 32'(s_ready), 32'd1);
    @(posedge clk); #1;

    // Vector table with bubbles and random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < NV; i++) begin
      send(vecs[i], i);
      if (i % 5 == 4) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b0;
    rand_bp = 1'b0;
    m_ready = 1'b1;
    drain();
    @(posedge clk); #1;

    // Four back-to-back operands, output stalled for 3 cycles.
    fork
      begin
        send(vecs[0], 100);
        send(vecs[3], 101);
        send(vecs[4], 102);
        send(vecs[9], 103);
        s_valid = 1'b0;
      end
      begin
        int n;
        n = 0;
        do begin
          @(posedge clk); #1;
          n++;
        end while (!m_valid && n < 50);
        m_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_s_ready", 100, 32'(s_ready), 32'd0);
          chk("stall_m_valid", 100, 32'(m_valid), 32'd1);
          chk("stall_y", 100, y, vecs[0].y);
          chk("stall_flags", 100, 32'(flags), 32'(vecs[0].f));
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
      end
    join
    drain();
    @(posedge clk); #1;

    // Reset with two operands in flight.
    m_ready = 1'b0;
    send(vecs[0], 200);
    send(vecs[3], 201);
    s_valid = 1'b0;
    chk("pre_reset_m_valid", 200, 32'(m_valid), 32'd1);
    rstn = 1'b0;
    #1;
    chk("inflight_reset_m_valid", 200, 32'(m_valid), 32'd0);
    chk("inflight_reset_s_ready", 200, 32'(s_ready), 32'd0);
    chk("inflight_reset_y", 200, y, 32'd0);
    chk("inflight_reset_flags", 200, 32'(flags), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    m_ready = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_valid) cnt++;
    end
    chk("post_reset_stale", 200, 32'(cnt), 32'd0);

    // INT_W=8 instance, one operand at a time with exact latency.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      s_valid8 = 1'b1; x8 = vecs8[i].x; rmode8 = vecs8[i].rm; is_unsigned8 = vecs8[i].uns;
      @(negedge clk);
      chk("w8_accept", i, 32'(s_ready8), 32'd1);
      @(posedge clk); #1;
      s_valid8 = 1'b0;
      @(negedge clk);
      chk("w8_latency_early", i, 32'(m_valid8), 32'd0);
      @(negedge clk);
      chk("w8_m_valid", i, 32'(m_valid8), 32'd1);
      chk("w8_y", i, 32'(y8), vecs8[i].y);
      chk("w8_flags", i, 32'(flags8), 32'(vecs8[i].f));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
